// File: rtl/atm_input_conditioner.sv
// ATM front-panel input conditioner.
// Raw pushbuttons and slide switches are synchronized, the buttons are
// debounced by independent per-button FSMs, and the resulting press events
// are arbitrated into single-cycle pulses. sw_out_o is frozen while any
// button is active so the controller sees the switch value from before
// the press began.

// Multi-bit synchronizer: one STAGES-deep flop chain per bit.
module atm_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [STAGES-1:0][W-1:0] sync_q;

  // Shift the raw sample through the chain; stage 0 is the metastable one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// Debounce FSM for one synchronized button.
module atm_btn_lane #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_i,
  output logic cand_o,      // press accepted this cycle (combinational)
  output logic held_o,      // registered debounced level
  output logic released_o   // FSM idle in RELEASED
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          held_q;

  // State, counter and held level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end
  end

  // Next-state logic; the counter is cleared whenever a state is entered
  // and saturates at CNT_MAX because reaching it always forces a transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_o  = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (sync_i) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_i) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          cand_o  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!sync_i) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync_i) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign held_o     = held_q;
  assign released_o = (state_q == RELEASED);
endmodule

// Top: three button lanes plus the switch synchronizer and arbitration.
module atm_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn3_raw_i,
  input  logic       btn2_raw_i,
  input  logic       btn1_raw_i,
  input  logic [3:0] sw_raw_i,
  output logic       btn3_pulse_o,
  output logic       btn2_pulse_o,
  output logic       btn1_pulse_o,
  output logic [3:0] sw_out_o,
  output logic [2:0] held_o,
  output logic       collision_o
);
  localparam int NUM_LANES = 3;

  // Lane index 0 is BTN1 (highest priority), 2 is BTN3.
  logic [NUM_LANES-1:0] btn_raw, btn_sync, cand, rel, win;
  logic [3:0]           sw_sync;
  logic [NUM_LANES-1:0] pulse_q;
  logic                 coll_q;
  logic [3:0]           sw_q;

  assign btn_raw = {btn3_raw_i, btn2_raw_i, btn1_raw_i};

  atm_sync #(.W(NUM_LANES), .STAGES(SYNC_STAGES)) u_btn_sync (
    .clk (clk), .rst (rst), .d_i (btn_raw), .q_o (btn_sync)
  );

  atm_sync #(.W(4), .STAGES(SYNC_STAGES)) u_sw_sync (
    .clk (clk), .rst (rst), .d_i (sw_raw_i), .q_o (sw_sync)
  );

  atm_btn_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane [NUM_LANES-1:0] (
    .clk        (clk),
    .rst        (rst),
    .sync_i     (btn_sync),
    .cand_o     (cand),
    .held_o     (held_o),
    .released_o (rel)
  );

  // Lowest set bit wins, which gives BTN1 > BTN2 > BTN3; losers are dropped.
  assign win = cand & (~cand + NUM_LANES'(1));

  // Register the arbitrated pulses and the coincidence flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_q <= '0;
      coll_q  <= 1'b0;
    end else begin
      pulse_q <= win;
      coll_q  <= (cand & (cand - NUM_LANES'(1))) != '0;
    end
  end

  // Track the switches only while every button is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sw_q <= '0;
    else if (&rel) sw_q <= sw_sync;
  end

  assign btn1_pulse_o = pulse_q[0];
  assign btn2_pulse_o = pulse_q[1];
  assign btn3_pulse_o = pulse_q[2];
  assign collision_o  = coll_q;
  assign sw_out_o     = sw_q;
endmodule

// File: tb/tb_atm_input_conditioner.sv
// Scoreboard bench for atm_input_conditioner with default parameters.
// Stimulus pushes the expected pulse event (cycle, pulse vector, collision,
// sw_out, held); the monitor pops one entry for every pulse the DUT shows.
module tb_atm_input_conditioner;
  logic       clk = 1'b0;
  logic       rst;
  logic       btn3_raw, btn2_raw, btn1_raw;
  logic [3:0] sw_raw;
  logic       btn3_pulse, btn2_pulse, btn1_pulse;
  logic [3:0] sw_out;
  logic [2:0] held;
  logic       collision;

  typedef struct {
    int         cyc;
    logic [2:0] pulse;
    logic       coll;
    logic [3:0] sw;
    logic [2:0] held;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_test = 0;
  int   n_fail = 0;

  atm_input_conditioner dut (
    .clk          (clk),
    .rst          (rst),
    .btn3_raw_i   (btn3_raw),
    .btn2_raw_i   (btn2_raw),
    .btn1_raw_i   (btn1_raw),
    .sw_raw_i     (sw_raw),
    .btn3_pulse_o (btn3_pulse),
    .btn2_pulse_o (btn2_pulse),
    .btn1_pulse_o (btn1_pulse),
    .sw_out_o     (sw_out),
    .held_o       (held),
    .collision_o  (collision)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_test++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_pulse(input logic [2:0] p, input logic c, input logic [3:0] s,
                              input logic [2:0] h, input int lat);
    exp_t e;
    e.cyc = cyc + lat; e.pulse = p; e.coll = c; e.sw = s; e.held = h;
    q.push_back(e);
  endtask

  // Monitor: every visible pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [2:0] p;
    exp_t       e;
    p = {btn3_pulse, btn2_pulse, btn1_pulse};
    if (!rst && collision && p == 3'b000)
      chk("collision_without_pulse", {31'd0, collision}, 32'd0);
    if (!rst && p != 3'b000) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, p}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("pulse_cycle", cyc,                  e.cyc);
        chk("pulse_vec",   {29'd0, p},           {29'd0, e.pulse});
        chk("collision",   {31'd0, collision},   {31'd0, e.coll});
        chk("sw_at_pulse", {28'd0, sw_out},      {28'd0, e.sw});
        chk("held_at_pulse", {29'd0, held},      {29'd0, e.held});
      end
    end
  end

  task automatic chk_idle(input string name);
    chk({name, "_pulses"}, {29'd0, btn3_pulse, btn2_pulse, btn1_pulse}, 32'd0);
    chk({name, "_held"},   {29'd0, held},      32'd0);
    chk({name, "_coll"},   {31'd0, collision}, 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1; btn1_raw = 0; btn2_raw = 0; btn3_raw = 0; sw_raw = 4'h0;
    @(negedge clk);
    chk_idle("reset");
    chk("reset_sw", {28'd0, sw_out}, 32'd0);
    tick(3);
    rst = 1'b0;
    tick(5);

    // BTN3 clean press, held 20 cycles.
    btn3_raw = 1;
    expect_pulse(3'b100, 1'b0, 4'h0, 3'b100, 7);
    tick(20);
    chk("btn3_held", {29'd0, held}, 32'd4);
    btn3_raw = 0;
    tick(12);
    chk_idle("btn3_release");

    // BTN2 chatter: never stable for long enough.
    for (int i = 0; i < 10; i++) begin
      btn2_raw = ~i[0];
      tick();
      chk("btn2_bounce_held", {31'd0, held[1]}, 32'd0);
    end
    btn2_raw = 0;
    tick(10);
    chk_idle("btn2_bounce");

    // BTN1 and BTN3 coincide: BTN1 wins, collision flagged.
    btn1_raw = 1; btn3_raw = 1;
    expect_pulse(3'b001, 1'b1, 4'h0, 3'b101, 7);
    tick(12);
    chk("coll_held", {29'd0, held}, 32'd5);
    btn1_raw = 0; btn3_raw = 0;
    tick(12);
    chk_idle("coll_release");

    // Switch change during debounce is hidden until the press is released.
    sw_raw = 4'h5;
    tick(5);
    chk("sw_idle_track", {28'd0, sw_out}, 32'h5);
    btn3_raw = 1;
    expect_pulse(3'b100, 1'b0, 4'h5, 3'b100, 7);
    tick(4);
    sw_raw = 4'hA;
    tick(8);
    chk("sw_frozen", {28'd0, sw_out}, 32'h5);
    btn3_raw = 0;
    k = 0;
    while (held != 3'b000 && k < 20) begin
      tick();
      k++;
    end
    chk("sw_release_timeout", {31'd0, (k >= 20)}, 32'd0);
    tick(3);
    chk("sw_updated", {28'd0, sw_out}, 32'hA);

    // BTN2 press with a one-cycle glitch high while releasing.
    btn2_raw = 1;
    expect_pulse(3'b010, 1'b0, 4'hA, 3'b010, 7);
    tick(10);
    btn2_raw = 0;
    tick(4);
    btn2_raw = 1;
    tick();
    btn2_raw = 0;
    tick(2);
    chk("glitch_rearm_held", {31'd0, held[1]}, 32'd1);
    tick(12);
    chk_idle("glitch_release");

    // Reset in the middle of a BTN1 debounce aborts it; held button re-presses.
    btn1_raw = 1;
    tick(4);
    rst = 1'b1;
    #1;
    chk_idle("midrst");
    chk("midrst_sw", {28'd0, sw_out}, 32'd0);
    tick(2);
    rst = 1'b0;
    expect_pulse(3'b001, 1'b0, 4'hA, 3'b001, 7);
    tick(12);
    chk("midrst_held", {29'd0, held}, 32'd1);
    btn1_raw = 0;
    tick(12);
    chk_idle("final");
    chk("pending_pulses", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/atm_input_conditioner.md
ATM_INPUT_CONDITIONER -- requirements
Module: atm_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized samples needed to accept a level change; SHALL be >= 2.
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop depth of every input synchronizer; SHALL be >= 2.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn3_raw, btn2_raw, btn1_raw  input  1 each  asynchronous bouncing pushbuttons; 1 = pressed.
REQ-006 sw_raw  input  4  asynchronous slide switches.
REQ-007 btn3_pulse, btn2_pulse, btn1_pulse  output  1 each  registered single-cycle press events for the ATM controller.
REQ-008 sw_out  output  4  registered synchronized switch value, coherent with button pulses.
REQ-009 held  output  3  registered debounced levels; held[2]=BTN3, held[1]=BTN2, held[0]=BTN1.
REQ-010 collision  output  1  registered one-cycle flag: pulses from more than one button qualified in the same cycle.

Function
REQ-011 Each button and each sw_raw bit SHALL pass through its own SYNC_STAGES-deep synchronizer before any other logic.
REQ-012 Each button SHALL have an independent FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus a counter of width ceil(log2(DEBOUNCE_CYCLES)); counter cleared on every state entry.
REQ-013 RELEASED: sync=1 -> PRESS_WAIT; else stay.
REQ-014 PRESS_WAIT: sync=0 -> RELEASED, no pulse; sync=1 and counter==DEBOUNCE_CYCLES-1 -> PRESSED and press candidate; else counter+1.
REQ-015 PRESSED: sync=0 -> RELEASE_WAIT; else stay; no further pulses while held (no auto-repeat).
REQ-016 RELEASE_WAIT: sync=1 -> PRESSED, no pulse; sync=0 and counter==DEBOUNCE_CYCLES-1 -> RELEASED; else counter+1; release never generates a pulse.
REQ-017 held[i] SHALL be 1 exactly while button i FSM is PRESSED or RELEASE_WAIT.
REQ-018 Latency raw rising edge (held stable) to pulse high SHALL be SYNC_STAGES+DEBOUNCE_CYCLES+1 clock edges; pulse width exactly 1 cycle.
REQ-019 Same-cycle candidates SHALL be arbitrated BTN1 > BTN2 > BTN3; only the winner pulses; losers are discarded (not deferred) but their FSMs still enter PRESSED.
REQ-020 collision SHALL pulse in the same cycle as the winning pulse whenever two or more candidates coincided.
REQ-021 At most one of btn1_pulse, btn2_pulse, btn3_pulse SHALL be high in any cycle.
REQ-022 sw_out SHALL load the synchronized sw_raw each cycle only when all three FSMs are RELEASED; otherwise hold, so sw_out during any pulse equals the switch value before that press began.
REQ-023 Counters SHALL never wrap; maximum value DEBOUNCE_CYCLES-1.

Reset
REQ-024 rst=1 SHALL immediately clear all synchronizer flops, counters, sw_out, held, collision and all pulses to 0, and force every FSM to RELEASED.
REQ-025 Reset asserted mid-debounce or mid-pulse SHALL abort with no pulse emitted; a button held through rst deassertion SHALL be treated as a new press and pulse once after full REQ-018 latency.

Verification
REQ-026 Defaults; btn3_raw 0->1 held 20 cycles -> btn3_pulse high for exactly one cycle at edge 7 after the change; held[2]=1 from then; no other pulses.
REQ-027 btn2_raw toggling 1,0,1,0 every cycle for 10 cycles then 0 -> no btn2_pulse, held[1] stays 0.
REQ-028 btn1_raw and btn3_raw rise in the same cycle, held -> btn1_pulse once, btn3_pulse never, collision=1 in that cycle, held=3'b101.
REQ-029 sw_raw=4'h5, press BTN3, change sw_raw to 4'hA during debounce -> sw_out=4'h5 during btn3_pulse; after release debounced, sw_out=4'hA within SYNC_STAGES+1 cycles.
REQ-030 Press BTN2, release with 1-cycle glitch high during RELEASE_WAIT, then release -> single btn2_pulse total; held[1] returns 0 after DEBOUNCE_CYCLES stable-low samples.
REQ-031 rst pulsed while btn1_raw held mid-PRESS_WAIT -> all outputs 0 immediately; after rst release, btn1_pulse once at edge 7.
